// File: rtl/pc_fetch_controller_pkg.sv
// Shared CPU definitions: fetch controller state encoding, fault causes and
// the default reset vector.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_controller_if.sv
// Instruction-memory fetch handshake between the fetch controller (master)
// and instruction memory (slave).
interface pc_fetch_controller_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/pc_fetch_controller_fetch_timeout_counter.sv
// Counts unacknowledged fetch cycles; expired flags the cycle whose count
// would reach TIMEOUT_CYCLES.
module fetch_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // Asserted during the last permitted waiting cycle, before the count lands.
   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/pc_fetch_controller.sv
// Program counter holder and fetch/retire sequencer for the unpipelined core,
// with a sticky fault trap on fetch timeout or misaligned next PC.
module pc_fetch_controller
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   pc_fetch_controller_if.master   imem,
   input  logic [31:0]             next_pc,
   input  logic                    exec_done,
   output logic [31:0]             pc,
   output logic [31:0]             pc_plus_four,
   output logic [31:0]             instr,
   output logic                    instr_valid,
   output logic [31:0]             retire_count,
   output logic                    fault,
   output logic [1:0]              fault_cause,
   output logic [31:0]             fault_pc
);

   state_t state;
   logic   wait_clear;
   logic   wait_enable;
   logic   wait_expired;

   assign wait_clear  = (state == FETCH) &&  imem.imem_ack;
   assign wait_enable = (state == FETCH) && !imem.imem_ack;

   fetch_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (wait_clear),
      .enable  (wait_enable),
      .expired (wait_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= RESET_VECTOR;
         instr        <= '0;
         retire_count <= '0;
         fault_cause  <= CAUSE_NONE;
         fault_pc     <= '0;
      end else begin
         case (state)
            FETCH: begin
               // An ack in the final permitted cycle takes priority over timeout.
               if (imem.imem_ack) begin
                  instr <= imem.imem_rdata;
                  state <= EXEC;
               end else if (wait_expired) begin
                  fault_cause <= CAUSE_TIMEOUT;
                  fault_pc    <= pc;
                  state       <= FAULT;
               end
            end
            EXEC: begin
               if (exec_done) begin
                  retire_count <= retire_count + 32'd1;
                  if (next_pc[1:0] == 2'b00) begin
                     pc    <= next_pc;
                     state <= FETCH;
                  end else begin
                     fault_cause <= CAUSE_MISALIGN;
                     fault_pc    <= next_pc;
                     state       <= FAULT;
                  end
               end
            end
            FAULT: begin
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   assign imem.imem_req  = (state == FETCH);
   assign imem.imem_addr = pc;
   assign instr_valid    = (state == EXEC);
   assign fault          = (state == FAULT);
   assign pc_plus_four   = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: a cycle-level behavioural model
// is compared against every output each cycle, plus literal spot checks.
module tb_pc_fetch_controller;

   localparam logic [31:0] RV = 32'h0000_0100;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        exec_done;
   logic        tie;
   logic [31:0] next_pc_drv;
   logic [31:0] next_pc;
   logic [31:0] pc;
   logic [31:0] pc_plus_four;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] retire_count;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_pc;

   pc_fetch_controller_if imem_bus ();

   assign next_pc = tie ? pc_plus_four : next_pc_drv;

   pc_fetch_controller #(
      .RESET_VECTOR   (RV),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem         (imem_bus),
      .next_pc      (next_pc),
      .exec_done    (exec_done),
      .pc           (pc),
      .pc_plus_four (pc_plus_four),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .retire_count (retire_count),
      .fault        (fault),
      .fault_cause  (fault_cause),
      .fault_pc     (fault_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: tracks whether we are executing, trapped, and how
   // long the current fetch has waited.
   bit          m_live    = 1'b0;
   bit          m_exec    = 1'b0;
   bit          m_trapped = 1'b0;
   int unsigned m_waited  = 0;
   logic [31:0] m_pc, m_instr, m_retire, m_fpc, m_target;
   logic [1:0]  m_cause;

   always @(posedge clk) begin
      m_target = tie ? (m_pc + 32'd4) : next_pc_drv;
      if (rst) begin
         m_live = 1'b1; m_exec = 1'b0; m_trapped = 1'b0; m_waited = 0;
         m_pc = RV; m_instr = '0; m_retire = '0; m_fpc = '0; m_cause = 2'b00;
      end else if (!m_live || m_trapped) begin
      end else if (m_exec) begin
         if (exec_done) begin
            m_retire = m_retire + 32'd1;
            if (m_target % 4 != 0) begin
               m_trapped = 1'b1; m_cause = 2'b10; m_fpc = m_target;
            end else begin
               m_pc = m_target; m_exec = 1'b0; m_waited = 0;
            end
         end
      end else if (imem_bus.imem_ack) begin
         m_instr = imem_bus.imem_rdata; m_exec = 1'b1; m_waited = 0;
      end else begin
         m_waited++;
         if (m_waited >= TO) begin
            m_trapped = 1'b1; m_cause = 2'b01; m_fpc = m_pc;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check32("m_imem_req",     {31'b0, imem_bus.imem_req}, {31'b0, !m_exec && !m_trapped});
         check32("m_imem_addr",    imem_bus.imem_addr, m_pc);
         check32("m_pc",           pc, m_pc);
         check32("m_pc_plus_four", pc_plus_four, m_pc + 32'd4);
         check32("m_instr_valid",  {31'b0, instr_valid}, {31'b0, m_exec && !m_trapped});
         check32("m_instr",        instr, m_instr);
         check32("m_retire_count", retire_count, m_retire);
         check32("m_fault",        {31'b0, fault}, {31'b0, m_trapped});
         check32("m_fault_cause",  {30'b0, fault_cause}, {30'b0, m_cause});
         check32("m_fault_pc",     fault_pc, m_fpc);
      end
   end

   // Starts at a negedge in FETCH; returns at the negedge after the retire edge.
   task automatic do_instr(input logic [31:0] word, input int ack_wait,
                           input logic use_tie, input logic [31:0] target);
      imem_bus.imem_ack = 1'b0;
      repeat (ack_wait) @(negedge clk);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = word;
      @(negedge clk);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      check32("exec_instr_valid", {31'b0, instr_valid}, 32'd1);
      check32("exec_instr", instr, word);
      tie         = use_tie;
      next_pc_drv = target;
      exec_done   = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      tie       = 1'b1;
   endtask

   task automatic pulse_ignored_inputs();
      imem_bus.imem_ack = 1'b1;
      exec_done         = 1'b1;
      tie               = 1'b0;
      next_pc_drv       = 32'h0000_0400;
      repeat (2) @(negedge clk);
      imem_bus.imem_ack = 1'b0;
      exec_done         = 1'b0;
      tie               = 1'b1;
   endtask

   initial begin
      rst = 1'b1; exec_done = 1'b0; tie = 1'b1; next_pc_drv = '0;
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
      repeat (2) @(negedge clk);
      check32("rst_pc", pc, 32'h100);
      check32("rst_retire", retire_count, 32'd0);
      check32("rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
      check32("rst_fault", {31'b0, fault}, 32'd0);
      rst = 1'b0;

      // Sequential run, then a branch from 0x108 to 0x200.
      check32("seq_addr0", imem_bus.imem_addr, 32'h100);
      do_instr(32'hA000_0001, 0, 1'b1, '0);
      check32("seq_retire1", retire_count, 32'd1);
      check32("seq_addr1", imem_bus.imem_addr, 32'h104);
      do_instr(32'hA000_0002, 0, 1'b1, '0);
      check32("seq_retire2", retire_count, 32'd2);
      check32("seq_addr2", imem_bus.imem_addr, 32'h108);
      do_instr(32'hA000_0003, 0, 1'b0, 32'h200);
      check32("seq_retire3", retire_count, 32'd3);
      check32("br_addr", imem_bus.imem_addr, 32'h200);
      check32("br_pc4", pc_plus_four, 32'h204);

      // Slow memory: ack on 3rd cycle, then on the 4th (limit) cycle.
      do_instr(32'hB000_0003, 2, 1'b1, '0);
      check32("slow3_fault", {31'b0, fault}, 32'd0);
      do_instr(32'hB000_0004, 3, 1'b1, '0);
      check32("slow4_fault", {31'b0, fault}, 32'd0);
      check32("slow4_addr", imem_bus.imem_addr, 32'h208);

      // Timeout at 0x208.
      repeat (3) @(negedge clk);
      check32("to_pre_fault", {31'b0, fault}, 32'd0);
      @(negedge clk);
      check32("to_fault", {31'b0, fault}, 32'd1);
      check32("to_cause", {30'b0, fault_cause}, 32'd1);
      check32("to_fault_pc", fault_pc, 32'h208);
      check32("to_req", {31'b0, imem_bus.imem_req}, 32'd0);
      pulse_ignored_inputs();
      check32("to_frozen_pc", pc, 32'h208);

      // Reset from FAULT with an ack during the reset cycle.
      rst = 1'b1; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hC0DE_0000;
      @(negedge clk);
      rst = 1'b0; imem_bus.imem_ack = 1'b0;
      check32("rf_pc", pc, 32'h100);
      check32("rf_fault", {31'b0, fault}, 32'd0);
      check32("rf_instr", instr, 32'd0);
      check32("rf_req", {31'b0, imem_bus.imem_req}, 32'd1);

      // Reset mid-fetch restores a full timeout window.
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check32("mid_no_fault", {31'b0, fault}, 32'd0);

      // Misaligned target from 0x100.
      do_instr(32'hD000_0001, 0, 1'b0, 32'h202);
      check32("mis_cause", {30'b0, fault_cause}, 32'd2);
      check32("mis_fault_pc", fault_pc, 32'h202);
      check32("mis_pc", pc, 32'h100);
      check32("mis_retire", retire_count, 32'd1);
      pulse_ignored_inputs();
      check32("mis_frozen_retire", retire_count, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Wrap-around of pc and retire_count.
      do_instr(32'hE000_0001, 0, 1'b0, 32'hFFFF_FFFC);
      check32("wrap_pc", pc, 32'hFFFF_FFFC);
      check32("wrap_pc4", pc_plus_four, 32'h0);
      #2;
      force dut.retire_count = 32'hFFFF_FFFF;
      m_retire = 32'hFFFF_FFFF;
      #1;
      release dut.retire_count;
      do_instr(32'hE000_0002, 0, 1'b1, '0);
      check32("wrap_retire", retire_count, 32'd0);
      check32("wrap_addr", imem_bus.imem_addr, 32'h0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
